// File: rtl/cla_pkg.sv
// Shared definitions for the 64-bit CLA datapath: opcode encodings, group size
// and the beat layout handed from the P/G stage to the lookahead tree.
package cla_pkg;

  localparam int CLA_GROUP = 4;
  localparam int CLA_WIDTH = 64;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_ADC   = 2'b10,
    OP_PASSA = 2'b11
  } cla_op_t;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH-1:0] g;
    logic                 c0;
    logic                 sa;
    logic                 sb;
  } pg_beat_t;

endpackage

// File: rtl/cla_pg_stage_gen.sv
// Combinational operand conditioning (subtract / carry-in / pass-A) followed by
// bitwise propagate/generate formation. Holds no state.
module cla_pg_gen
  import cla_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_p,
  output logic [WIDTH-1:0] o_g,
  output logic             o_c0,
  output logic             o_sa,
  output logic             o_sb
);

  cla_op_t          w_op;
  logic [WIDTH-1:0] w_b_cond;

  assign w_op = cla_op_t'(i_op);

  // Subtraction is a + ~b + 1, so the +1 rides in on c0 rather than an adder here.
  always_comb begin
    w_b_cond = i_b;
    o_c0     = 1'b0;
    case (w_op)
      OP_ADD:   w_b_cond = i_b;
      OP_SUB: begin
        w_b_cond = ~i_b;
        o_c0     = 1'b1;
      end
      OP_ADC:   o_c0 = i_cin;
      OP_PASSA: w_b_cond = '0;
      default:  w_b_cond = i_b;
    endcase
  end

  assign o_p  = i_a ^ w_b_cond;
  assign o_g  = i_a & w_b_cond;
  assign o_sa = i_a[WIDTH-1];
  assign o_sb = w_b_cond[WIDTH-1];

endmodule

// File: rtl/cla_pg_stage.sv
// Registered P/G stage: conditions operands, forms P/G and holds results in a
// 2-entry in-order buffer so the downstream tree can stall without a comb path.
module cla_pg_stage
  import cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic             out_c0,
  output logic             out_sa,
  output logic             out_sb
);

  if (((WIDTH % GROUP) != 0) || (GROUP != CLA_GROUP)) begin : g_bad_param
    $error("cla_pg_stage: WIDTH must be a multiple of GROUP and GROUP must be 4");
  end

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c0;
    logic             sa;
    logic             sb;
  } beat_t;

  beat_t      w_beat;
  beat_t      w_head;
  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic [1:0] w_count_next;
  logic       r_in_ready;
  logic       w_push;
  logic       w_pop;

  cla_pg_gen #(.WIDTH(WIDTH)) u_gen (
    .i_a   (in_a),
    .i_b   (in_b),
    .i_op  (in_op),
    .i_cin (in_cin),
    .o_p   (w_beat.p),
    .o_g   (w_beat.g),
    .o_c0  (w_beat.c0),
    .o_sa  (w_beat.sa),
    .o_sb  (w_beat.sb)
  );

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = (r_count != 2'd0) & out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // in_ready is registered from the next count so it never depends on out_ready
  // combinationally, and stays low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_beat;
      end
      r_wr_ptr   <= r_wr_ptr ^ w_push;
      r_rd_ptr   <= r_rd_ptr ^ w_pop;
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != 2'd2);
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_p     = w_head.p;
  assign out_g     = w_head.g;
  assign out_c0    = w_head.c0;
  assign out_sa    = w_head.sa;
  assign out_sb    = w_head.sb;

endmodule

// File: tb/tb_cla_pg_stage.sv
// Directed self-checking bench for cla_pg_stage: per-opcode conditioning,
// backpressure, full-rate streaming and asynchronous reset with a full buffer.
module tb_cla_pg_stage;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic [W-1:0] out_g;
  logic         out_c0;
  logic         out_sa;
  logic         out_sb;

  int checks;
  int errors;

  cla_pg_stage #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_g     (out_g),
    .out_c0    (out_c0),
    .out_sa    (out_sa),
    .out_sb    (out_sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; the DUT samples them at the next rising edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic cin);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; in_cin = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid/ready %b expected 00", {out_valid, in_ready});
    end
    checks++;
    if ({out_p, out_g, out_c0, out_sa, out_sb} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_payload: got p=%h g=%h expected 0", out_p, out_g);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: got valid/ready %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_add();
    send(2'b00, 64'h0000_0000_0000_00FF, 64'h1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_latency: got out_valid %b expected 1", out_valid);
    end
    checks++;
    if ({out_p, out_g, out_c0, out_sa, out_sb} !== {64'hFE, 64'h1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_pg: got p=%h g=%h c0=%b sa=%b sb=%b expected p=fe g=1 c0=0 sa=0 sb=0",
               out_p, out_g, out_c0, out_sa, out_sb);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_p} !== {1'b1, 64'hFE}) begin
      errors++;
      $display("[TB] FAIL add_hold: got valid=%b p=%h expected valid=1 p=fe", out_valid, out_p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_pop: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_sub();
    send(2'b01, 64'h5, 64'h3, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_p, out_g, out_c0, out_sa, out_sb} !==
        {1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h4, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL sub_pg: got v=%b p=%h g=%h c0=%b sa=%b sb=%b expected v=1 p=fffffffffffffff9 g=4 c0=1 sa=0 sb=1",
               out_valid, out_p, out_g, out_c0, out_sa, out_sb);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_adc();
    send(2'b10, {W{1'b1}}, {W{1'b1}}, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_p, out_g, out_c0, out_sa, out_sb} !==
        {1'b1, 64'h0, {W{1'b1}}, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL adc_pg: got v=%b p=%h g=%h c0=%b sa=%b sb=%b expected v=1 p=0 g=all-ones c0=1 sa=1 sb=1",
               out_valid, out_p, out_g, out_c0, out_sa, out_sb);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_passa();
    send(2'b11, 64'h8000_0000_0000_0001, 64'hFFFF_0000_FFFF_0000, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_p, out_g, out_c0, out_sa, out_sb} !==
        {1'b1, 64'h8000_0000_0000_0001, 64'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL passa_pg: got v=%b p=%h g=%h c0=%b sa=%b sb=%b expected v=1 p=8000000000000001 g=0 c0=0 sa=1 sb=0",
               out_valid, out_p, out_g, out_c0, out_sa, out_sb);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(2'b00, 64'hA1, 64'h0, 1'b0);
    @(negedge clk);
    send(2'b00, 64'hB2, 64'h0, 1'b0);
    @(negedge clk);
    send(2'b00, 64'hC3, 64'h0, 1'b0);
    checks++;
    if ({in_ready, out_valid, out_p} !== {1'b0, 1'b1, 64'hA1}) begin
      errors++;
      $display("[TB] FAIL bp_full: got ready=%b valid=%b p=%h expected ready=0 valid=1 p=a1",
               in_ready, out_valid, out_p);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, out_p} !== {1'b0, 64'hA1}) begin
      errors++;
      $display("[TB] FAIL bp_third_refused: got ready=%b p=%h expected ready=0 p=a1", in_ready, out_p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_p} !== {1'b1, 1'b1, 64'hB2}) begin
      errors++;
      $display("[TB] FAIL bp_first_pop: got ready=%b valid=%b p=%h expected ready=1 valid=1 p=b2",
               in_ready, out_valid, out_p);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_p} !== {1'b1, 64'hC3}) begin
      errors++;
      $display("[TB] FAIL bp_third_out: got valid=%b p=%h expected valid=1 p=c3", out_valid, out_p);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_drain: got valid/ready %b expected 01", {out_valid, in_ready});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        checks++;
        if ({out_valid, out_p} !== {1'b1, 64'(k)}) begin
          errors++;
          $display("[TB] FAIL stream_out[%0d]: got valid=%b p=%h expected valid=1 p=%h",
                   k, out_valid, out_p, 64'(k));
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", k, in_ready);
      end
      send(2'b00, 64'(k + 1), 64'h0, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_p} !== {1'b1, 64'd100}) begin
      errors++;
      $display("[TB] FAIL stream_last: got valid=%b p=%h expected valid=1 p=64", out_valid, out_p);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_empty: got out_valid %b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(2'b01, 64'hAA, 64'h0, 1'b0);
    @(negedge clk);
    send(2'b01, 64'hBB, 64'h0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_g, out_c0} !== {1'b0, 1'b1, 64'hAA, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rstmid_full: got ready=%b valid=%b g=%h c0=%b expected ready=0 valid=1 g=aa c0=1",
               in_ready, out_valid, out_g, out_c0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, out_p, out_g, out_c0} !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_async: got valid=%b ready=%b p=%h g=%h c0=%b expected all 0",
               out_valid, in_ready, out_p, out_g, out_c0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rstmid_release: got valid/ready %b expected 01", {out_valid, in_ready});
    end
    send(2'b00, 64'h77, 64'h0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_p, out_c0} !== {1'b1, 64'h77, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rstmid_new_beat: got valid=%b p=%h c0=%b expected valid=1 p=77 c0=0",
               out_valid, out_p, out_c0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_no_stale: got out_valid %b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_adc();
    test_passa();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
